// File: rtl/count_sched_ctrl_pkg.sv
// count_sched_ctrl_pkg
// Shared definitions for the count scheduler: FSM state encoding and the
// default event-count width and terminal count.
package count_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N      = 5;
  localparam int DEF_TARGET = 20;

endpackage

// File: rtl/count_sched_ctrl_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. The pointer selects which requester wins
// when both request at once: ptr=0 favours requester 1, ptr=1 favours
// requester 2. With a single requester, that requester always wins.
// The pointer toggles only when en is high.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (pointer -> requester 1)
//   en              toggle the pointer on this edge (a contended grant was taken)
//   req1, req2      requests
//   gnt1, gnt2      combinational winner (at most one high)
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req1,
  input  logic req2,
  output logic gnt1,
  output logic gnt2
);

  logic ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (en) begin
      ptr <= ~ptr;
    end
  end

  assign gnt1 = req1 & (~req2 | ~ptr);
  assign gnt2 = req2 & (~req1 |  ptr);

endmodule

// File: rtl/count_sched_ctrl.sv
// count_sched_ctrl
// Schedules a counting job: clears an external two-input datapath counter,
// grants event requests from two requesters until TARGET events have been
// granted, then pulses done. Near the end of a job only one event may fit,
// so a contended request is resolved by a round-robin arbiter.
//
// Handshake: req1/req2 are levels; an event is consumed in exactly the
// cycle its gnt is high (gnt is combinational from state, count and req),
// so a requester must hold req until it sees gnt.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           pulse, begins a job from IDLE
//   abort           level, ends a job in CLEAR/RUN without done
//   req1, req2      event requests
//   gnt1, gnt2      grants, also the datapath counter increments
//   clr             clear strobe to the datapath counter (CLEAR state)
//   busy            high in CLEAR and RUN
//   done            one-cycle pulse in DONE
//   count           events granted in the current (or last) job
//   fsm_state       current FSM state, for observation
module count_sched_ctrl
  import count_sched_ctrl_pkg::*;
#(
  parameter int n      = DEF_N,
  parameter int TARGET = DEF_TARGET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         req1,
  input  logic         req2,
  output logic         gnt1,
  output logic         gnt2,
  output logic         clr,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] count,
  output state_t       fsm_state
);

  localparam logic [n-1:0] TGT  = n'(TARGET);
  localparam logic [n-1:0] LAST = n'(TARGET - 1);

  state_t       state;
  logic         run_ok;
  logic         last;
  logic         arb_en;
  logic         arb_g1;
  logic         arb_g2;
  logic [n-1:0] next_count;

  // Abort forces the grants off in the same cycle.
  assign run_ok = (state == RUN) && !abort;
  // Only one event left: a double grant would overshoot TARGET.
  assign last   = (count == LAST);
  assign arb_en = run_ok && last && req1 && req2;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req1 (req1),
    .req2 (req2),
    .gnt1 (arb_g1),
    .gnt2 (arb_g2)
  );

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (run_ok) begin
      if (last) begin
        gnt1 = arb_g1;
        gnt2 = arb_g2;
      end else begin
        gnt1 = req1;
        gnt2 = req2;
      end
    end
  end

  assign next_count = count + n'(gnt1) + n'(gnt2);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      clr   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      clr  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= CLEAR;
            clr   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          // Grants are zero under abort, so count holds in that case.
          count <= next_count;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (next_count == TGT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched_ctrl.sv
module tb_count_sched_ctrl;
  import count_sched_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  // Instance A: TARGET=20, instance B: TARGET=5, instance C: TARGET=1
  logic start_a = 0, abort_a = 0, req1_a = 0, req2_a = 0;
  logic gnt1_a, gnt2_a, clr_a, busy_a, done_a;
  logic [4:0] count_a;
  state_t st_a;
  logic start_b = 0, abort_b = 0, req1_b = 0, req2_b = 0;
  logic gnt1_b, gnt2_b, clr_b, busy_b, done_b;
  logic [4:0] count_b;
  state_t st_b;
  logic start_c = 0, abort_c = 0, req1_c = 0, req2_c = 0;
  logic gnt1_c, gnt2_c, clr_c, busy_c, done_c;
  logic [4:0] count_c;
  state_t st_c;

  always #5 clk = ~clk;

  count_sched_ctrl #(.n(5), .TARGET(20)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .req1(req1_a), .req2(req2_a),
    .gnt1(gnt1_a), .gnt2(gnt2_a), .clr(clr_a), .busy(busy_a), .done(done_a),
    .count(count_a), .fsm_state(st_a));

  count_sched_ctrl #(.n(5), .TARGET(5)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .req1(req1_b), .req2(req2_b),
    .gnt1(gnt1_b), .gnt2(gnt2_b), .clr(clr_b), .busy(busy_b), .done(done_b),
    .count(count_b), .fsm_state(st_b));

  count_sched_ctrl #(.n(5), .TARGET(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .req1(req1_c), .req2(req2_c),
    .gnt1(gnt1_c), .gnt2(gnt2_c), .clr(clr_c), .busy(busy_c), .done(done_c),
    .count(count_c), .fsm_state(st_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output vectors below are {gnt1, gnt2, clr, busy, done}.
  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00000 || count_a !== 5'd0 || st_a !== IDLE) begin
      errors++;
      $display("FAIL reset_a outs=%b count=%0d st=%0d exp outs=00000 count=0 st=0",
               {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, count_a, st_a);
    end
    start_a = 1; req1_a = 1; req2_a = 1;
    start_b = 1; start_c = 1;
    tick();
    tick();
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00000 || st_a !== IDLE ||
        st_b !== IDLE || st_c !== IDLE || count_b !== 5'd0 || count_c !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold outs_a=%b st_a=%0d st_b=%0d st_c=%0d exp 00000 and IDLE",
               {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, st_a, st_b, st_c);
    end
    start_a = 0; req1_a = 0; req2_a = 0; start_b = 0; start_c = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_run();
    start_a = 1; req1_a = 1; req2_a = 1;
    tick();
    start_a = 0;
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00110 || st_a !== CLEAR) begin
      errors++;
      $display("FAIL full_clear outs=%b st=%0d exp outs=00110 st=1", {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, st_a);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b11010 || count_a !== 5'(2 * i)) begin
        errors++;
        $display("FAIL full_run[%0d] outs=%b count=%0d exp outs=11010 count=%0d",
                 i, {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, count_a, 2 * i);
      end
      tick();
    end
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00001 || count_a !== 5'd20 || st_a !== DONE) begin
      errors++;
      $display("FAIL full_done outs=%b count=%0d st=%0d exp outs=00001 count=20 st=3",
               {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, count_a, st_a);
    end
    tick();
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00000 || count_a !== 5'd20 || st_a !== IDLE) begin
      errors++;
      $display("FAIL full_idle outs=%b count=%0d st=%0d exp outs=00000 count=20 st=0",
               {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, count_a, st_a);
    end
    req1_a = 0; req2_a = 0;
    tick();
  endtask

  task automatic test_abort();
    start_a = 1; req1_a = 1; req2_a = 0;
    tick();
    start_a = 0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (count_a !== 5'd7 || st_a !== RUN) begin
      errors++;
      $display("FAIL abort_pre count=%0d st=%0d exp count=7 st=2", count_a, st_a);
    end
    abort_a = 1;
    #1;
    vectors++;
    if ({gnt1_a, gnt2_a} !== 2'b00 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_gnt gnts=%b busy=%b exp gnts=00 busy=1", {gnt1_a, gnt2_a}, busy_a);
    end
    tick();
    abort_a = 0;
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00000 || count_a !== 5'd7 || st_a !== IDLE) begin
      errors++;
      $display("FAIL abort_idle outs=%b count=%0d st=%0d exp outs=00000 count=7 st=0",
               {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, count_a, st_a);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (done_a !== 1'b0 || count_a !== 5'd7) begin
        errors++;
        $display("FAIL abort_after[%0d] done=%b count=%0d exp done=0 count=7", i, done_a, count_a);
      end
    end
    req1_a = 0;
  endtask

  task automatic test_async_reset();
    start_a = 1; req1_a = 1; req2_a = 1;
    tick();
    start_a = 0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (count_a !== 5'd12 || st_a !== RUN) begin
      errors++;
      $display("FAIL areset_pre count=%0d st=%0d exp count=12 st=2", count_a, st_a);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({gnt1_a, gnt2_a, clr_a, busy_a, done_a} !== 5'b00000 || count_a !== 5'd0 || st_a !== IDLE) begin
      errors++;
      $display("FAIL areset_now outs=%b count=%0d st=%0d exp outs=00000 count=0 st=0",
               {gnt1_a, gnt2_a, clr_a, busy_a, done_a}, count_a, st_a);
    end
    @(negedge clk);
    rst = 1'b1;
    start_a = 1;
    tick();
    start_a = 0;
    vectors++;
    if (clr_a !== 1'b1 || st_a !== CLEAR || done_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_first_start clr=%b st=%0d done=%b exp clr=1 st=1 done=0", clr_a, st_a, done_a);
    end
    abort_a = 1;
    tick();
    abort_a = 0; req1_a = 0; req2_a = 0;
    vectors++;
    if (st_a !== IDLE || count_a !== 5'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_clear_abort st=%0d count=%0d busy=%b exp st=0 count=0 busy=0", st_a, count_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] last_req [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
    logic [1:0] exp_last [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
    for (int j = 0; j < 4; j++) begin
      start_b = 1; req1_b = 1; req2_b = 1;
      tick();
      start_b = 0;
      vectors++;
      if (clr_b !== 1'b1 || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL b2b_clear[%0d] clr=%b busy=%b exp clr=1 busy=1", j, clr_b, busy_b);
      end
      tick();
      vectors++;
      if ({gnt1_b, gnt2_b} !== 2'b11 || count_b !== 5'd0) begin
        errors++;
        $display("FAIL b2b_run0[%0d] gnts=%b count=%0d exp gnts=11 count=0", j, {gnt1_b, gnt2_b}, count_b);
      end
      tick();
      vectors++;
      if ({gnt1_b, gnt2_b} !== 2'b11 || count_b !== 5'd2) begin
        errors++;
        $display("FAIL b2b_run1[%0d] gnts=%b count=%0d exp gnts=11 count=2", j, {gnt1_b, gnt2_b}, count_b);
      end
      tick();
      {req1_b, req2_b} = last_req[j];
      #1;
      vectors++;
      if ({gnt1_b, gnt2_b} !== exp_last[j] || count_b !== 5'd4) begin
        errors++;
        $display("FAIL b2b_last[%0d] gnts=%b count=%0d exp gnts=%b count=4", j, {gnt1_b, gnt2_b}, count_b, exp_last[j]);
      end
      tick();
      vectors++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || count_b !== 5'd5) begin
        errors++;
        $display("FAIL b2b_done[%0d] done=%b busy=%b count=%0d exp done=1 busy=0 count=5", j, done_b, busy_b, count_b);
      end
      tick();
      vectors++;
      if (done_b !== 1'b0 || st_b !== IDLE || count_b !== 5'd5) begin
        errors++;
        $display("FAIL b2b_idle[%0d] done=%b st=%0d count=%0d exp done=0 st=0 count=5", j, done_b, st_b, count_b);
      end
    end
    req1_b = 0; req2_b = 0;
  endtask

  task automatic test_target_one();
    start_c = 1; abort_c = 1; req1_c = 1; req2_c = 1;
    tick();
    vectors++;
    if (st_c !== IDLE || clr_c !== 1'b0) begin
      errors++;
      $display("FAIL t1_start_abort st=%0d clr=%b exp st=0 clr=0", st_c, clr_c);
    end
    abort_c = 0;
    tick();
    start_c = 0;
    vectors++;
    if (clr_c !== 1'b1 || st_c !== CLEAR) begin
      errors++;
      $display("FAIL t1_clear clr=%b st=%0d exp clr=1 st=1", clr_c, st_c);
    end
    tick();
    vectors++;
    if ({gnt1_c, gnt2_c} !== 2'b10 || count_c !== 5'd0) begin
      errors++;
      $display("FAIL t1_grant gnts=%b count=%0d exp gnts=10 count=0", {gnt1_c, gnt2_c}, count_c);
    end
    tick();
    start_c = 1;
    vectors++;
    if (done_c !== 1'b1 || count_c !== 5'd1) begin
      errors++;
      $display("FAIL t1_done done=%b count=%0d exp done=1 count=1", done_c, count_c);
    end
    tick();
    vectors++;
    if (st_c !== IDLE || {clr_c, busy_c, done_c} !== 3'b000) begin
      errors++;
      $display("FAIL t1_start_in_done st=%0d clr/busy/done=%b exp st=0 000", st_c, {clr_c, busy_c, done_c});
    end
    tick();
    start_c = 0;
    vectors++;
    if (clr_c !== 1'b1 || st_c !== CLEAR) begin
      errors++;
      $display("FAIL t1_restart clr=%b st=%0d exp clr=1 st=1", clr_c, st_c);
    end
    tick();
    vectors++;
    if ({gnt1_c, gnt2_c} !== 2'b01) begin
      errors++;
      $display("FAIL t1_grant2 gnts=%b exp gnts=01", {gnt1_c, gnt2_c});
    end
    tick();
    vectors++;
    if (done_c !== 1'b1 || count_c !== 5'd1) begin
      errors++;
      $display("FAIL t1_done2 done=%b count=%0d exp done=1 count=1", done_c, count_c);
    end
    req1_c = 0; req2_c = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_target_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_sched_ctrl.md
COUNT_SCHED_CTRL -- requirements
Module: count_sched_ctrl

Interface
REQ-001 Parameter n, default 5: width of the event count tracked and driven to the datapath counter.
REQ-002 Parameter TARGET, default 20: terminal event count; legal range 1 .. 2^n-1.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  pulse; begins a counting job when in IDLE, ignored otherwise.
REQ-006 abort  in  1  level; terminates a job in progress.
REQ-007 req1, req2  in  1 each  event requests from requester 1 and requester 2.
REQ-008 gnt1, gnt2  out  1 each  grants; they also drive cnt1/cnt2 of the two-input datapath counter.
REQ-009 clr  out  1  clear strobe to the datapath counter.
REQ-010 busy  out  1  high while a job is active, from CLEAR through RUN.
REQ-011 done  out  1  one-cycle pulse when TARGET is reached.
REQ-012 count  out  n  events granted in the current job.

Function
REQ-013 FSM states: IDLE, CLEAR, RUN, DONE.
REQ-014 IDLE: on start=1, go to CLEAR; otherwise stay.
REQ-015 CLEAR: lasts exactly one cycle; clr=1; count<=0; go to RUN.
REQ-016 RUN, remaining = TARGET-count >= 2: gnt1=req1, gnt2=req2.
REQ-017 RUN, remaining = 1, one request: grant it.
REQ-018 RUN, remaining = 1, both requests: grant only the round-robin winner; the pointer then toggles.
REQ-019 Round-robin pointer reset value favours requester 1; it updates only on a contended grant.
REQ-020 Grants are combinational from state, pointer, count and req; they are zero outside RUN.
REQ-021 count advances by gnt1+gnt2 (0, 1 or 2) per RUN cycle; it never exceeds TARGET, so there is no wrap-around.
REQ-022 RUN: when next count == TARGET, go to DONE on that edge.
REQ-023 DONE: lasts one cycle; done=1, busy=0; count holds TARGET; then go to IDLE.
REQ-024 IDLE: count holds the last job's value until the next CLEAR.
REQ-025 abort=1 in CLEAR or RUN: grants are forced to 0 that cycle; next state is IDLE; done is not asserted; count holds.
REQ-026 abort takes priority over TARGET completion in the same cycle.
REQ-027 start in the same cycle as DONE is ignored; start in IDLE with abort=1 is ignored.
REQ-028 TARGET=1 with both requests: exactly one grant, then DONE.

Reset
REQ-029 While rst=0: state=IDLE, count=0, pointer=requester 1, and gnt1, gnt2, clr, busy, done all 0.
REQ-030 Reset mid-job discards the job immediately; no done pulse follows.
REQ-031 After rst deasserts, the first start is accepted on the next posedge clk.

Structure
REQ-032 Shared package holds: the state enumeration (IDLE, CLEAR, RUN, DONE), default n, default TARGET.
REQ-033 Sub-module rr_arb2 (two-way round-robin arbiter with pointer register and enable) is instantiated once.
REQ-034 The datapath counter is external; this block only drives gnt1/gnt2/clr and tracks count itself.

Verification
REQ-035 Reset then start, req1=req2=1 constantly, TARGET=20 -> clr for 1 cycle, 10 RUN cycles of double grants, done pulse with count=20.
REQ-036 TARGET=5, req1=req2=1 -> grants 2,2, then a single grant to requester 1; count=5; pointer now favours requester 2.
REQ-037 Two back-to-back jobs, TARGET=5, both requesting -> the second job's final single grant goes to requester 2.
REQ-038 Job running, count=7, abort=1 -> grants 0 that cycle, IDLE next, done never pulses, count stays 7.
REQ-039 rst=0 asynchronously mid-RUN at count=12 -> all outputs 0 and count=0 before the next clock edge.
REQ-040 start asserted during DONE, TARGET=1 -> ignored, block returns to IDLE; a new start one cycle later is accepted.
